// File: rtl/axis_iic_pkg.sv
// rtl/axis_iic_pkg.sv - shared types and constants for the I2C target
// Contents: FSM state type iic_sub_fsm_t, bus acknowledge levels, general call address.
package axis_iic_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        WR_DATA   = 4'd3,
        WR_ACK    = 4'd4,
        RD_LOAD   = 4'd5,
        RD_DATA   = 4'd6,
        RD_ACK    = 4'd7,
        WAIT_STOP = 4'd8
    } iic_sub_fsm_t;

    localparam logic       IIC_ACK          = 1'b0;
    localparam logic       IIC_NACK         = 1'b1;
    localparam logic [6:0] IIC_GENERAL_CALL = 7'h00;

endpackage

// File: rtl/iic_line_filter.sv
// rtl/iic_line_filter.sv - synchronizer and glitch filter for one I2C line
// Ports: clk_i2c/reset (sync, active-high); line_in raw pad level;
//        line_out filtered level; rise/fall one-cycle strobes of line_out.
module iic_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 3
) (
    input  logic clk_i2c,
    input  logic reset,
    input  logic line_in,
    output logic line_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic [3:0]             stable_cnt;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];

    // Idle I2C lines are high, so reset everything to 1 to avoid a
    // spurious edge coming out of reset.
    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            sync       <= '1;
            line_out   <= 1'b1;
            stable_cnt <= '0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_out == line_out) begin
                stable_cnt <= '0;
            end else if (stable_cnt == 4'(GLITCH_CYCLES - 1)) begin
                // New level has now been seen GLITCH_CYCLES times in a row.
                line_out   <= sync_out;
                rise       <= sync_out;
                fall       <= ~sync_out;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/axis_iic_sub.sv
// rtl/axis_iic_sub.sv - I2C target bridging bus writes/reads to AXI-Stream
// Ports: clk_i2c oversampling clock, reset sync active-high;
//        SCL_I/SDA_I pad levels, SCL_T/SDA_T open-drain enables (1 = release);
//        m_axis_* received write bytes (tuser = first byte after address);
//        s_axis_* bytes returned on reads; busy = FSM not idle.
module axis_iic_sub #(
    parameter logic [6:0] DEVICE_ADDR   = 7'h50,
    parameter int         SYNC_STAGES   = 2,
    parameter int         GLITCH_CYCLES = 3
) (
    input  logic       clk_i2c,
    input  logic       reset,
    input  logic       SCL_I,
    input  logic       SDA_I,
    output logic       SCL_T,
    output logic       SDA_T,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tuser,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy
);
    import axis_iic_pkg::*;

    iic_sub_fsm_t state;
    logic         scl, scl_rise, scl_fall;
    logic         sda, sda_rise, sda_fall;
    logic         start, stop;
    logic [2:0]   bit_cnt;
    logic [6:0]   shreg;
    logic [7:0]   rx_byte;
    logic [7:0]   rd_byte;
    logic         rd_n_wr;
    logic         phase2;     // second half of an ACK phase
    logic         fall_d;     // scl_fall delayed one cycle: SDA hold margin
    logic         first_byte;
    logic         sda_t, scl_t;
    logic         m_full;

    iic_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filter (
        .clk_i2c (clk_i2c),
        .reset   (reset),
        .line_in (SCL_I),
        .line_out(scl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    iic_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_sda_filter (
        .clk_i2c (clk_i2c),
        .reset   (reset),
        .line_in (SDA_I),
        .line_out(sda),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    // Both lines share the same filter latency, so their relative ordering
    // on the pads is preserved here.
    assign start   = sda_fall & scl;
    assign stop    = sda_rise & scl;
    assign rx_byte = {shreg, sda};
    assign m_full  = m_axis_tvalid & ~m_axis_tready;

    assign SDA_T         = sda_t;
    assign SCL_T         = scl_t;
    assign busy          = (state != IDLE);
    assign s_axis_tready = (state == RD_LOAD) & s_axis_tvalid & ~start & ~stop;

    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd7;
            shreg         <= '0;
            rd_byte       <= '0;
            rd_n_wr       <= 1'b0;
            phase2        <= 1'b0;
            fall_d        <= 1'b0;
            first_byte    <= 1'b0;
            sda_t         <= 1'b1;
            scl_t         <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
        end else begin
            fall_d <= scl_fall;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (start) begin
                state   <= ADDR;
                bit_cnt <= 3'd7;
                sda_t   <= 1'b1;
                scl_t   <= 1'b1;
                phase2  <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                sda_t  <= 1'b1;
                scl_t  <= 1'b1;
                phase2 <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                if (rx_byte[7:1] == DEVICE_ADDR && rx_byte[7:1] != IIC_GENERAL_CALL) begin
                                    state      <= ADDR_ACK;
                                    rd_n_wr    <= rx_byte[0];
                                    first_byte <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    ADDR_ACK, WR_ACK: begin
                        // First fall: start driving ACK. Second fall: ninth clock done.
                        if (scl_fall) begin
                            if (!phase2) begin
                                sda_t  <= IIC_ACK;
                                phase2 <= 1'b1;
                            end else begin
                                sda_t   <= IIC_NACK;
                                phase2  <= 1'b0;
                                bit_cnt <= 3'd7;
                                state   <= (state == ADDR_ACK && rd_n_wr) ? RD_LOAD : WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                if (m_full) begin
                                    state <= WAIT_STOP;
                                end else begin
                                    m_axis_tdata  <= rx_byte;
                                    m_axis_tuser  <= first_byte;
                                    m_axis_tvalid <= 1'b1;
                                    first_byte    <= 1'b0;
                                    state         <= WR_ACK;
                                end
                            end
                        end
                    end
                    RD_LOAD: begin
                        if (s_axis_tready) begin
                            rd_byte <= s_axis_tdata;
                            sda_t   <= s_axis_tdata[7];
                            bit_cnt <= 3'd7;
                            state   <= RD_DATA;
                        end else begin
                            scl_t <= 1'b0;
                        end
                    end
                    RD_DATA: begin
                        // SCL is released one cycle after bit 7 is on SDA, giving setup time.
                        scl_t <= 1'b1;
                        if (fall_d) begin
                            if (bit_cnt == 3'd0) begin
                                sda_t  <= 1'b1;
                                phase2 <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_t   <= rd_byte[bit_cnt - 3'd1];
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        // Fetch the next byte only after SCL falls again, so SDA
                        // never moves while SCL is high.
                        if (scl_rise) begin
                            if (sda == IIC_NACK) begin
                                state <= WAIT_STOP;
                            end else begin
                                phase2 <= 1'b1;
                            end
                        end else if (scl_fall && phase2) begin
                            phase2  <= 1'b0;
                            bit_cnt <= 3'd7;
                            state   <= RD_LOAD;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        sda_t <= 1'b1;
                        scl_t <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        sda_t <= 1'b1;
                        scl_t <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_iic_sub.sv
// tb/tb_axis_iic_sub.sv - self-checking bench for axis_iic_sub with a bus-manager model
module tb_axis_iic_sub;

    localparam logic [6:0] DEV = 7'h50;
    localparam int         SS  = 2;
    localparam int         GC  = 3;
    localparam int         Q   = 10;   // quarter SCL period in clk_i2c cycles

    logic       clk_i2c = 1'b0;
    logic       reset;
    logic       mgr_scl, mgr_sda;
    logic       scl_bus, sda_bus;
    logic       SCL_T, SDA_T;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tuser, m_axis_tvalid, m_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid, s_axis_tready;
    logic       busy;

    assign scl_bus = mgr_scl & SCL_T;
    assign sda_bus = mgr_sda & SDA_T;

    axis_iic_sub #(.DEVICE_ADDR(DEV), .SYNC_STAGES(SS), .GLITCH_CYCLES(GC)) dut (
        .clk_i2c      (clk_i2c),
        .reset        (reset),
        .SCL_I        (scl_bus),
        .SDA_I        (sda_bus),
        .SCL_T        (SCL_T),
        .SDA_T        (SDA_T),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .busy         (busy)
    );

    initial forever #5 clk_i2c = ~clk_i2c;

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         m_hs      = 0;
    int         s_hs      = 0;
    logic [8:0] m_seen[$];
    logic [8:0] m_exp[$];
    logic [7:0] s_q[$];
    logic       s_take;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sink monitor: records every accepted m_axis beat as {tuser, tdata}.
    initial forever begin
        @(negedge clk_i2c);
        if (m_axis_tvalid && m_axis_tready) begin
            m_seen.push_back({m_axis_tuser, m_axis_tdata});
            m_hs++;
        end
    end

    // Source: presents the head of s_q, pops on handshake.
    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        forever begin
            @(negedge clk_i2c);
            s_take = s_axis_tvalid && s_axis_tready;
            @(posedge clk_i2c);
            #1;
            if (s_take) begin
                s_hs++;
                void'(s_q.pop_front());
            end
            if (s_q.size() != 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = s_q[0];
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 8'h00;
            end
        end
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i2c);
        #1;
    endtask

    task automatic wait_scl_high();
        int t;
        t = 0;
        while (scl_bus !== 1'b1 && t < 2000) begin
            wait_cycles(1);
            t++;
        end
        check("scl_release", scl_bus, 1'b1);
    endtask

    // One SCL clock: SDA set during low, sampled mid-high. Entered and left with SCL low.
    task automatic clk_bit(input logic b, output logic rb);
        mgr_sda = b;
        wait_cycles(Q);
        mgr_scl = 1'b1;
        wait_scl_high();
        wait_cycles(Q);
        rb = sda_bus;
        wait_cycles(Q);
        mgr_scl = 1'b0;
        wait_cycles(Q);
    endtask

    task automatic start_cond();
        mgr_sda = 1'b1;
        wait_cycles(Q);
        mgr_scl = 1'b1;
        wait_scl_high();
        wait_cycles(Q);
        mgr_sda = 1'b0;
        wait_cycles(Q);
        mgr_scl = 1'b0;
        wait_cycles(Q);
    endtask

    task automatic stop_cond();
        mgr_sda = 1'b0;
        wait_cycles(Q);
        mgr_scl = 1'b1;
        wait_scl_high();
        wait_cycles(Q);
        mgr_sda = 1'b1;
        wait_cycles(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
        clk_bit(1'b1, d);
        ack = (d == 1'b0);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, d);
            b[i] = d;
        end
        clk_bit(~mack, d);
    endtask

    logic       ack;
    logic [7:0] rb;
    int         m_hs0, s_hs0, stall_bad;
    logic       saw_busy;
    logic [6:0] r_addr;
    logic       r_rw, r_acc, r_first;
    int         r_n;
    logic [7:0] r_bytes[$];
    logic [7:0] r_b;

    initial begin
        reset         = 1'b1;
        mgr_scl       = 1'b1;
        mgr_sda       = 1'b1;
        m_axis_tready = 1'b1;
        wait_cycles(5);
        check("rst_scl_t", SCL_T, 1'b1);
        check("rst_sda_t", SDA_T, 1'b1);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tdata", m_axis_tdata, 8'h00);
        check("rst_m_tuser", m_axis_tuser, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_cycles(20);

        // Three-byte write to our address.
        start_cond();
        check("wr_busy", busy, 1'b1);
        write_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b1);
        write_byte(8'h12, ack); check("wr_b1_ack", ack, 1'b1);
        m_exp.push_back({1'b1, 8'h12});
        write_byte(8'h34, ack); check("wr_b2_ack", ack, 1'b1);
        m_exp.push_back({1'b0, 8'h34});
        stop_cond();
        check("wr_idle", busy, 1'b0);

        // Two-byte read, manager ACKs then NACKs.
        s_hs0 = s_hs;
        s_q.push_back(8'h5A);
        s_q.push_back(8'hC3);
        start_cond();
        write_byte(8'hA1, ack); check("rd_addr_ack", ack, 1'b1);
        read_byte(1'b1, rb);    check("rd_b0", rb, 8'h5A);
        read_byte(1'b0, rb);    check("rd_b1", rb, 8'hC3);
        check("rd_wait_stop_busy", busy, 1'b1);
        stop_cond();
        check("rd_s_handshakes", s_hs - s_hs0, 2);
        check("rd_idle", busy, 1'b0);

        // Wrong address and general call are NACKed, nothing streamed.
        m_hs0 = m_hs;
        start_cond();
        write_byte(8'hA2, ack); check("bad_addr_nack", ack, 1'b0);
        write_byte(8'h3C, ack); check("bad_data_nack", ack, 1'b0);
        check("bad_wait_stop", busy, 1'b1);
        stop_cond();
        start_cond();
        write_byte(8'h00, ack); check("gen_call_nack", ack, 1'b0);
        stop_cond();
        check("bad_no_m", m_hs - m_hs0, 0);
        check("bad_idle", busy, 1'b0);

        // Read with a long source stall: SCL must be held low throughout.
        s_hs0 = s_hs;
        start_cond();
        write_byte(8'hA1, ack); check("stall_addr_ack", ack, 1'b1);
        wait_cycles(2 * Q);
        stall_bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (SCL_T !== 1'b0) stall_bad++;
            wait_cycles(1);
        end
        check("stall_scl_low", stall_bad, 0);
        check("stall_bus_low", scl_bus, 1'b0);
        s_q.push_back(8'h77);
        read_byte(1'b0, rb);    check("stall_byte", rb, 8'h77);
        stop_cond();
        check("stall_s_handshakes", s_hs - s_hs0, 1);

        // Back-pressure: second byte NACKed and dropped.
        m_axis_tready = 1'b0;
        start_cond();
        write_byte(8'hA0, ack); check("bp_addr_ack", ack, 1'b1);
        write_byte(8'h66, ack); check("bp_b1_ack", ack, 1'b1);
        write_byte(8'h99, ack); check("bp_b2_nack", ack, 1'b0);
        stop_cond();
        check("bp_held_valid", m_axis_tvalid, 1'b1);
        check("bp_held_data", m_axis_tdata, 8'h66);
        check("bp_held_user", m_axis_tuser, 1'b1);
        m_exp.push_back({1'b1, 8'h66});
        m_axis_tready = 1'b1;
        wait_cycles(5);
        check("bp_drained", m_axis_tvalid, 1'b0);

        // SDA glitch one cycle shorter than the filter: no start.
        mgr_sda = 1'b0;
        wait_cycles(GC - 1);
        mgr_sda = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            wait_cycles(1);
        end
        check("glitch_short_no_start", saw_busy, 1'b0);

        // Pulse of exactly the filter length: start then stop.
        mgr_sda = 1'b0;
        wait_cycles(GC);
        mgr_sda = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            wait_cycles(1);
        end
        check("glitch_full_start", saw_busy, 1'b1);
        check("glitch_full_stop", busy, 1'b0);

        // Stop after four bits of a data byte: partial byte discarded.
        m_hs0 = m_hs;
        start_cond();
        write_byte(8'hA0, ack); check("part_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, rb[0]);
        stop_cond();
        check("part_idle", busy, 1'b0);
        check("part_no_valid", m_axis_tvalid, 1'b0);
        check("part_no_m", m_hs - m_hs0, 0);

        // Reset during a stretched read releases both lines.
        start_cond();
        write_byte(8'hA1, ack); check("rst_mid_addr_ack", ack, 1'b1);
        wait_cycles(2 * Q);
        check("rst_mid_stretch", SCL_T, 1'b0);
        reset = 1'b1;
        wait_cycles(1);
        check("rst_mid_scl", SCL_T, 1'b1);
        check("rst_mid_sda", SDA_T, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        wait_cycles(2 * Q);
        stop_cond();

        // Randomized transactions against the transaction-level model.
        for (int t = 0; t < 8; t++) begin
            r_addr = ($urandom_range(0, 2) == 0) ? 7'($urandom) : DEV;
            r_rw   = 1'($urandom_range(0, 1));
            r_n    = $urandom_range(1, 3);
            r_acc  = (r_addr == DEV) && (r_addr != 7'h00);
            r_bytes.delete();
            for (int i = 0; i < r_n; i++) r_bytes.push_back(8'($urandom));
            if (r_acc && r_rw) begin
                foreach (r_bytes[i]) s_q.push_back(r_bytes[i]);
            end
            s_hs0 = s_hs;
            start_cond();
            write_byte({r_addr, r_rw}, ack);
            check("rnd_addr_ack", ack, r_acc);
            if (r_acc && !r_rw) begin
                r_first = 1'b1;
                for (int i = 0; i < r_n; i++) begin
                    write_byte(r_bytes[i], ack);
                    check("rnd_wr_ack", ack, 1'b1);
                    m_exp.push_back({r_first, r_bytes[i]});
                    r_first = 1'b0;
                end
            end else if (r_acc && r_rw) begin
                for (int i = 0; i < r_n; i++) begin
                    read_byte(i < r_n - 1, r_b);
                    check("rnd_rd_byte", r_b, r_bytes[i]);
                end
            end
            stop_cond();
            check("rnd_idle", busy, 1'b0);
            check("rnd_s_handshakes", s_hs - s_hs0, (r_acc && r_rw) ? r_n : 0);
        end
        wait_cycles(5);

        check("m_stream_len", m_seen.size(), m_exp.size());
        for (int i = 0; i < m_exp.size() && i < m_seen.size(); i++) begin
            check("m_stream_item", m_seen[i], m_exp[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
